// File: rtl/rotate_point_pkg.sv
// Shared math package for the point rotator.
// Holds coordinate/fixed-point widths, degree constants, the FSM state
// enum and a saturate-to-coordinate helper used by the datapath.
package rotate_point_pkg;

  localparam int INT_BITS   = 16;  // signed coordinate / angle width
  localparam int FLOAT_BITS = 16;  // signed fixed-point trig width
  localparam int FRAC_BITS  = 14;  // fractional bits of FLOAT_BITS (Q2.14)
  localparam int PROD_BITS  = INT_BITS + FLOAT_BITS;

  localparam int DEG_360 = 360;
  localparam int DEG_180 = 180;
  localparam int DEG_90  = 90;

  typedef enum logic [1:0] {IDLE, NORM, TRIG, RUN} state_t;

  // Clamp a wide signed value into the signed INT_BITS range.
  function automatic logic signed [INT_BITS-1:0] sat_int(input logic signed [PROD_BITS+1:0] v);
    logic signed [PROD_BITS+1:0] hi, lo;
    hi = '0;
    hi[INT_BITS-2:0] = '1;
    lo = '1;
    lo[INT_BITS-2:0] = '0;
    if (v > hi)      return hi[INT_BITS-1:0];
    else if (v < lo) return lo[INT_BITS-1:0];
    else             return v[INT_BITS-1:0];
  endfunction

endpackage

// File: rtl/rotate_point_cos_deg.sv
// cos_deg: combinational cosine of an integer angle in degrees.
//   deg  : signed degrees, expected -180..180 (larger magnitudes clamp to 180)
//   cosv : cos(deg) in signed Q2.14
// A quarter-wave table (0..90) plus symmetry covers the full range.
module cos_deg
  import rotate_point_pkg::*;
(
  input  logic signed [INT_BITS-1:0]   deg,
  output logic signed [FLOAT_BITS-1:0] cosv
);

  localparam logic signed [INT_BITS-1:0] D90  = INT_BITS'(DEG_90);
  localparam logic signed [INT_BITS-1:0] D180 = INT_BITS'(DEG_180);

  // round(16384 * cos(i deg)), i = 0..90
  localparam logic [15:0] COS_TBL [0:90] = '{
    16'd16384, 16'd16382, 16'd16374, 16'd16362, 16'd16344, 16'd16322, 16'd16294, 16'd16262, 16'd16225, 16'd16182,
    16'd16135, 16'd16083, 16'd16026, 16'd15964, 16'd15897, 16'd15826, 16'd15749, 16'd15668, 16'd15582, 16'd15491,
    16'd15396, 16'd15296, 16'd15191, 16'd15082, 16'd14968, 16'd14849, 16'd14726, 16'd14598, 16'd14466, 16'd14330,
    16'd14189, 16'd14044, 16'd13894, 16'd13741, 16'd13583, 16'd13421, 16'd13255, 16'd13085, 16'd12911, 16'd12733,
    16'd12551, 16'd12365, 16'd12176, 16'd11983, 16'd11786, 16'd11585, 16'd11381, 16'd11174, 16'd10963, 16'd10749,
    16'd10531, 16'd10311, 16'd10087, 16'd9860,  16'd9630,  16'd9397,  16'd9162,  16'd8923,  16'd8682,  16'd8438,
    16'd8192,  16'd7943,  16'd7692,  16'd7438,  16'd7182,  16'd6924,  16'd6664,  16'd6402,  16'd6138,  16'd5872,
    16'd5604,  16'd5334,  16'd5063,  16'd4790,  16'd4516,  16'd4240,  16'd3964,  16'd3686,  16'd3406,  16'd3126,
    16'd2845,  16'd2563,  16'd2280,  16'd1997,  16'd1713,  16'd1428,  16'd1143,  16'd857,   16'd572,   16'd286,
    16'd0
  };

  logic signed [INT_BITS-1:0]   mag;
  logic [6:0]                   idx;
  logic                         neg;
  logic signed [FLOAT_BITS-1:0] val;

  always_comb begin
    mag = deg[INT_BITS-1] ? -deg : deg;
    // Out-of-range (and the -2^(N-1) negate overflow) collapse to 180.
    if (mag[INT_BITS-1] || mag > D180) mag = D180;
    neg = 1'b0;
    idx = 7'(mag);
    if (mag > D90) begin
      neg = 1'b1;
      idx = 7'(D180 - mag);
    end
    val  = FLOAT_BITS'(COS_TBL[idx]);
    cosv = neg ? -val : val;
  end

endmodule

// File: rtl/rotate_point_sat_round.sv
// sat_round: round-half-up, arithmetic shift by FRAC_BITS, saturate.
//   r : signed PROD_BITS+1 fixed-point sum of two products
//   y : signed INT_BITS integer result
module sat_round
  import rotate_point_pkg::*;
(
  input  logic signed [PROD_BITS:0]   r,
  output logic signed [INT_BITS-1:0]  y
);

  localparam logic signed [PROD_BITS+1:0] RND =
    {{(PROD_BITS+2-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

  logic signed [PROD_BITS+1:0] rnd, sh;

  always_comb begin
    rnd = (PROD_BITS+2)'(r) + RND;
    sh  = rnd >>> FRAC_BITS;
    y   = sat_int(sh);
  end

endmodule

// File: rtl/rotate_point.sv
// rotate_point: rotates vertex offsets about a pivot by a programmed angle.
//   clk, rst                 : clock, synchronous active-high reset
//   angle_valid/angle_ready  : load angle + pivot_x/pivot_y (IDLE or drained RUN)
//   in_valid/in_ready        : point offset in_x/in_y (only in RUN)
//   out_valid/out_ready      : rotated absolute point out_x/out_y
// Angle load runs NORM (wrap to -180..179) then TRIG (cos/sin lookup),
// then a two-register pipeline: products, then round/saturate/pivot add.
module rotate_point
  import rotate_point_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       angle_valid,
  output logic                       angle_ready,
  input  logic signed [INT_BITS-1:0] angle,
  input  logic signed [INT_BITS-1:0] pivot_x,
  input  logic signed [INT_BITS-1:0] pivot_y,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [INT_BITS-1:0] in_x,
  input  logic signed [INT_BITS-1:0] in_y,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [INT_BITS-1:0] out_x,
  output logic signed [INT_BITS-1:0] out_y
);

  localparam logic signed [INT_BITS-1:0] D90  = INT_BITS'(DEG_90);
  localparam logic signed [INT_BITS-1:0] D180 = INT_BITS'(DEG_180);
  localparam logic signed [INT_BITS-1:0] D360 = INT_BITS'(DEG_360);

  state_t state, state_nxt;

  logic       ang_acc, in_acc, adv1, adv2;
  logic [2:1] vld_pipe;  // [1] product stage, [2] output register

  logic signed [INT_BITS-1:0]   ang_q, a_n, a_n_nxt, s_deg, piv_x, piv_y;
  logic signed [FLOAT_BITS-1:0] cos_c, sin_s, c_w, s_w;
  logic signed [PROD_BITS-1:0]  xe, ye, ce, se;
  logic signed [PROD_BITS-1:0]  p_xc, p_ys, p_xs, p_yc;
  logic signed [PROD_BITS:0]    r_x, r_y;
  logic signed [INT_BITS-1:0]   rs_x, rs_y;
  logic signed [PROD_BITS+1:0]  sum_x, sum_y;

  // Handshake / flow control
  assign adv2        = !vld_pipe[2] || out_ready;
  assign adv1        = !vld_pipe[1] || adv2;
  assign angle_ready = (state == IDLE) || (state == RUN && vld_pipe == 2'b00);
  assign ang_acc     = angle_valid && angle_ready;
  // Block a point in the same cycle as a reload so it cannot pick up the new pivot.
  assign in_ready    = (state == RUN) && adv1 && !ang_acc;
  assign in_acc      = in_valid && in_ready;
  assign out_valid   = vld_pipe[2];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ang_acc) state_nxt = NORM;
      NORM:    state_nxt = TRIG;
      TRIG:    state_nxt = RUN;
      RUN:     if (ang_acc) state_nxt = NORM;
      default: state_nxt = IDLE;
    endcase
  end

  // Angle wrap to -180..179, and sin expressed as cos(a - 90) wrapped again.
  always_comb begin
    a_n_nxt = ang_q;
    if (ang_q >= D180)      a_n_nxt = ang_q - D360;
    else if (ang_q < -D180) a_n_nxt = ang_q + D360;
    s_deg = a_n - D90;
    if (s_deg < -D180) s_deg = s_deg + D360;
  end

  cos_deg u_cos (.deg(a_n),   .cosv(c_w));
  cos_deg u_sin (.deg(s_deg), .cosv(s_w));

  assign xe = PROD_BITS'(in_x);
  assign ye = PROD_BITS'(in_y);
  assign ce = PROD_BITS'(cos_c);
  assign se = PROD_BITS'(sin_s);

  assign r_x = (PROD_BITS+1)'(p_xc) - (PROD_BITS+1)'(p_ys);
  assign r_y = (PROD_BITS+1)'(p_xs) + (PROD_BITS+1)'(p_yc);

  sat_round u_rx (.r(r_x), .y(rs_x));
  sat_round u_ry (.r(r_y), .y(rs_y));

  assign sum_x = (PROD_BITS+2)'(rs_x) + (PROD_BITS+2)'(piv_x);
  assign sum_y = (PROD_BITS+2)'(rs_y) + (PROD_BITS+2)'(piv_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      ang_q    <= '0;
      piv_x    <= '0;
      piv_y    <= '0;
      a_n      <= '0;
      cos_c    <= '0;
      sin_s    <= '0;
      vld_pipe <= '0;
      p_xc     <= '0;
      p_ys     <= '0;
      p_xs     <= '0;
      p_yc     <= '0;
      out_x    <= '0;
      out_y    <= '0;
    end else begin
      if (ang_acc) begin
        ang_q <= angle;
        piv_x <= pivot_x;
        piv_y <= pivot_y;
      end
      if (state == NORM) a_n <= a_n_nxt;
      if (state == TRIG) begin
        cos_c <= c_w;
        sin_s <= s_w;
      end
      if (adv1) begin
        vld_pipe[1] <= in_acc;
        if (in_acc) begin
          p_xc <= xe * ce;
          p_ys <= ye * se;
          p_xs <= xe * se;
          p_yc <= ye * ce;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          out_x <= sat_int(sum_x);
          out_y <= sat_int(sum_y);
        end
      end
    end
  end

endmodule

// File: doc/rotate_point.md
ROTATE_POINT -- requirements
Module: rotate_point

Interface
REQ-001 Parameters: none; widths come from constants.h: INT_BITS (signed integer coordinate/angle width), FLOAT_BITS (signed fixed-point width), FRAC_BITS (fractional bits of FLOAT_BITS).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 angle_valid  in  1  new rotation configuration offered.
REQ-005 angle_ready  out  1  configuration accepted this cycle when angle_valid && angle_ready.
REQ-006 angle  in  INT_BITS  signed degrees; legal range -360..360.
REQ-007 pivot_x, pivot_y  in  INT_BITS each  signed pivot, captured with angle.
REQ-008 in_valid / in_ready  in / out  1 each  point handshake.
REQ-009 in_x, in_y  in  INT_BITS each  signed offset of vertex from pivot.
REQ-010 out_valid / out_ready  out / in  1 each  result handshake.
REQ-011 out_x, out_y  out  INT_BITS each  signed rotated absolute coordinate.

Function
REQ-012 FSM states: IDLE (no angle loaded), NORM, TRIG, RUN.
REQ-013 angle_ready SHALL be 1 in IDLE, and in RUN only when both pipeline stages and the output register are empty.
REQ-014 On angle accept: capture angle, pivot_x, pivot_y; go to NORM.
REQ-015 NORM (1 cycle): register a_n = angle normalised to -180..179 (add/subtract 360 as needed; 180 -> -180, 360 -> 0, -360 -> 0); go to TRIG.
REQ-016 TRIG (1 cycle): register C = cos(a_n) and S = cos(a_n - 90, wrapped to -180..179), both FLOAT_BITS, from two cos_deg instances; go to RUN.
REQ-017 in_ready SHALL be 1 only in RUN and when stage 1 can advance (stage 1 empty or stage 2 can advance; stage 2 can advance when out_valid=0 or out_ready=1).
REQ-018 Stage 1 (register on in accept): P_xc = in_x*C, P_ys = in_y*S, P_xs = in_x*S, P_yc = in_y*C, each INT_BITS+FLOAT_BITS signed.
REQ-019 Stage 2 (output register): r_x = P_xc - P_ys, r_y = P_xs + P_yc (one guard bit); round by adding 2^(FRAC_BITS-1) then arithmetic shift right FRAC_BITS; saturate to INT_BITS; add pivot; saturate again to INT_BITS.
REQ-020 Latency: point accepted at edge N appears with out_valid=1 after edge N+2 when out_ready is held 1; throughput one point per cycle.
REQ-021 Backpressure: while out_valid=1 and out_ready=0, out_x/out_y/out_valid and stage 1 SHALL hold; no point dropped, duplicated or reordered.
REQ-022 Simultaneous out handshake and in accept in one cycle SHALL both take effect (full-rate streaming).
REQ-023 angle_valid while angle_ready=0 SHALL be ignored; points after a new angle accept use only the new C/S/pivot.
REQ-024 in_valid in IDLE/NORM/TRIG SHALL be ignored (in_ready=0).
REQ-025 Angle outside -360..360: result undefined, no hang; FSM still reaches RUN.

Reset
REQ-026 rst=1 SHALL force state IDLE, angle_ready=1, in_ready=0, out_valid=0, out_x=out_y=0, C=S=0, pivot=0, both pipeline valid bits 0.
REQ-027 rst mid-stream SHALL discard all in-flight points; after rst the block requires a new angle before accepting points.

Structure
REQ-028 FSM state enum and the 360/180/90 degree constants SHALL live in the shared math package; widths stay in constants.h.
REQ-029 Trig SHALL reuse existing cos_deg (two instances); one new sub-module natural: sat_round (round-shift-saturate to INT_BITS), instantiated for x and y.

Verification (±1 LSB tolerance on trig-derived results)
REQ-030 angle=0, pivot=(100,100), point (10,5) -> out (110,105) two cycles after accept.
REQ-031 angle=90, same pivot/point -> (95,110); angle=-90 -> (105,90); angle=180 -> (90,95); angle=360 and angle=-360 -> (110,105).
REQ-032 Stream 8 points back-to-back, out_ready low for cycles 3-7 -> all 8 outputs in order, in_ready drops within 1 cycle of stall, no loss.
REQ-033 angle=0, pivot=(32000,0), point (32767,0) with INT_BITS=16 -> out_x=32767 (saturated); point (-32768,0), pivot (-100,0) -> -32768.
REQ-034 angle_valid pulsed while 3 points in flight -> angle_ready=0, ignored; after drain, new angle 90 accepted, NORM+TRIG take 2 cycles, subsequent points use 90.
REQ-035 rst asserted with 2 points in flight -> next cycle out_valid=0, in_ready=0, angle_ready=1; no stale output after reload.
